// File: rtl/shift_add_multiplier.sv
`default_nettype none
// ============================================================================
//  Module   : shift_add_multiplier
//  Purpose  : Sequential unsigned radix-2 shift-and-add multiplier with a
//             start/done handshake and a fixed WIDTH-cycle latency.
//  Ports    : clk      - system clock, rising edge
//             rst      - synchronous active-high reset
//             start    - request; sampled only in IDLE or DONE
//             a, b     - multiplicand / multiplier, captured on accept
//             busy     - high while iterating (CALC)
//             done     - one-cycle completion pulse
//             product  - 2*WIDTH result, held until the next completion
//  Revision : 1.0 - initial release
// ============================================================================
module shift_add_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    logic [1:0]         state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH:0]     acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    logic               w_accept;
    logic               w_last;
    logic [WIDTH:0]     w_sum;

    // New operands are taken from IDLE and also from DONE, which is what
    // allows back-to-back operation without an idle cycle.
    assign w_accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign w_last   = (state_q == S_CALC) && (cnt_q == LAST_ITER);

    // Upper accumulator plus the (conditionally) selected multiplicand; the
    // extra MSB keeps the carry so the shift below never loses it.
    assign w_sum = acc_q + ({1'b0, mcand_q} & {(WIDTH+1){mplier_q[0]}});

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_CALC;
            S_CALC:  if (w_last) state_d = S_DONE;
            S_DONE:  state_d = start ? S_CALC : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs, decoded purely from the state register
    // ------------------------------------------------------------------
    always_comb begin
        busy = (state_q == S_CALC);
        done = (state_q == S_DONE);
    end

    assign product = product_q;

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        if (w_accept) begin
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
        end else if (state_q == S_CALC) begin
            // {acc, mplier} >> 1 after the add; the LSB of the sum drops
            // into the top of the multiplier shift register.
            acc_d    = {1'b0, w_sum[WIDTH:1]};
            mplier_d = {w_sum[0], mplier_q[WIDTH-1:1]};
            cnt_d    = cnt_q + CW'(1);
            if (w_last) begin
                product_d = {w_sum, mplier_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

endmodule
`default_nettype wire
